load_store_unit: RTL and testbench

- Sits between the pipeline MEM stage and the data memory.
- Converts RISC-V load/store requests (byte, halfword, word; signed/unsigned) into word-aligned memory accesses.
- Extracts and extends load data.
- Performs read-modify-write for sub-word stores, because the data memory only writes whole words.
- Flags misaligned or illegal accesses without touching memory.

---
 rtl/load_store_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: turns RISC-V B/H/W loads and stores into word accesses for a memory that only writes whole words.
// Latency from accept (A): error A+1, SW A+2, load A+2+READ_LATENCY, SB/SH A+3+READ_LATENCY.
// Backpressure: reqReady is high only in IDLE, so one request is in flight and the source holds reqValid until accepted.
//
// Ports:
//   clk, rst_n                        clock (rising edge) and asynchronous active-low reset
//   reqValid/reqReady                 request handshake
//   reqWrite, reqFunct3               store/load select and RISC-V width/sign code
//   reqAddress, reqWriteData          byte address and store data (low lanes used for B/H)
//   respValid, respError, respData    one-cycle completion pulse, error flag, extended load data
//   memRead, memWrite                 one-cycle memory strobes, never high together
//   memAddress, memWriteData          word-aligned address and full write word
//   memReadData                       word from memory, READ_LATENCY cycles after memRead
module load_store_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [2:0]  reqFunct3,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqWriteData,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respError,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_t;

  // Index of the last RD_WAIT cycle; memReadData is valid in that cycle.
  localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

  state_t      state_q, state_d;
  logic [1:0]  wait_cnt_q, wait_cnt_d;
  logic        req_write_q, req_write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  // Illegal codes, stores of the unsigned variants, and accesses not aligned to their size.
  function automatic logic req_bad(input logic wr, input logic [2:0] f3, input logic [1:0] lane);
    logic illegal;
    logic misaligned;
    illegal    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (wr && f3[2]);
    misaligned = ((f3[1:0] == 2'b01) && lane[0]) ||
                 ((f3[1:0] == 2'b10) && (lane != 2'b00));
    return illegal || misaligned;
  endfunction

  // Pick the addressed lane out of the read word and extend it; f3[2] selects zero extension.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   r = {{24{b[7] & ~f3[2]}}, b};
      2'b01:   r = {{16{h[15] & ~f3[2]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overwrite only the addressed lane of the old word with the low bits of the store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] m;
    m = word;
    if (size == 2'b00) begin
      case (lane)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end else if (size == 2'b01) begin
      if (lane[1]) m[31:16] = wd[15:0];
      else         m[15:0]  = wd[15:0];
    end else begin
      m = wd;
    end
    return m;
  endfunction

  assign reqReady = (state_q == IDLE);

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    req_write_d   = req_write_q;
    funct3_d      = funct3_q;
    lane_d        = lane_q;
    wdata_d       = wdata_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    // Strobes and response fields are single-cycle pulses; they default low every cycle.
    resp_valid_d  = 1'b0;
    resp_error_d  = 1'b0;
    resp_data_d   = 32'd0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (reqValid) begin
          req_write_d   = reqWrite;
          funct3_d      = reqFunct3;
          lane_d        = reqAddress[1:0];
          wdata_d       = reqWriteData;
          mem_address_d = {reqAddress[31:2], 2'b00};
          if (req_bad(reqWrite, reqFunct3, reqAddress[1:0])) begin
            // Rejected without any memory traffic.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else if (reqWrite && (reqFunct3[1:0] == 2'b10)) begin
            state_d     = WR;
            mem_write_d = 1'b1;
            mem_wdata_d = reqWriteData;
          end else begin
            // Loads and sub-word stores both start with a read of the whole word.
            state_d    = RD_REQ;
            mem_read_d = 1'b1;
          end
        end
      end

      RD_REQ: begin
        state_d    = RD_WAIT;
        wait_cnt_d = 2'd0;
      end

      RD_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          if (req_write_q) begin
            state_d     = WR;
            mem_write_d = 1'b1;
            mem_wdata_d = store_merge(memReadData, wdata_q, funct3_q[1:0], lane_q);
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_data_d  = load_extract(memReadData, funct3_q, lane_q);
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end

      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset clears everything at once, which also drops any write that was about to be issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wait_cnt_q    <= 2'd0;
      req_write_q   <= 1'b0;
      funct3_q      <= 3'd0;
      lane_q        <= 2'd0;
      wdata_q       <= 32'd0;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= 1'b0;
      resp_data_q   <= 32'd0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= 32'd0;
      mem_wdata_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      req_write_q   <= req_write_d;
      funct3_q      <= funct3_d;
      lane_q        <= lane_d;
      wdata_q       <= wdata_d;
      resp_valid_q  <= resp_valid_d;
      resp_error_q  <= resp_error_d;
      resp_data_q   <= resp_data_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign respValid    = resp_valid_q;
  assign respError    = resp_error_q;
  assign respData     = resp_data_q;
  assign memRead      = mem_read_q;
  assign memWrite     = mem_write_q;
  assign memAddress   = mem_address_q;
  assign memWriteData = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: two instances (READ_LATENCY 1 and 3) against a memory model and a per-cycle reference model.
// Latency: n/a (bench).
// Backpressure: bench holds each request until the DUT accepts it.
module tb_load_store_unit;

  localparam int NI   = 2;
  localparam int NCYC = 1024;
  localparam int NW   = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  logic        rst_n       [NI];
  logic        req_valid   [NI];
  logic        req_write   [NI];
  logic [2:0]  req_funct3  [NI];
  logic [31:0] req_address [NI];
  logic [31:0] req_wdata   [NI];
  wire         req_ready   [NI];
  wire         resp_valid  [NI];
  wire         resp_error  [NI];
  wire  [31:0] resp_data   [NI];
  wire         mem_read    [NI];
  wire         mem_write   [NI];
  wire  [31:0] mem_addr    [NI];
  wire  [31:0] mem_wdata   [NI];
  wire  [31:0] mem_rdata   [NI];

  // Memory the DUT talks to.
  logic [31:0] env_mem [NI][NW];
  logic [31:0] pipe_d  [NI][3];
  logic [2:0]  pipe_v  [NI];
  int          wr_cnt  [NI];
  bit          env_init = 1'b0;

  // Reference model state.
  logic [31:0] model_mem  [NI][NW];
  int          busy_until [NI];
  int          model_acc  [NI];
  bit          cmp_init = 1'b0;
  bit          exp_rd   [NI][NCYC];
  bit          exp_wr   [NI][NCYC];
  bit          exp_hold [NI][NCYC];
  bit          exp_rv   [NI][NCYC];
  bit          exp_re   [NI][NCYC];
  logic [31:0] exp_addr [NI][NCYC];
  logic [31:0] exp_wd   [NI][NCYC];
  logic [31:0] exp_rdat [NI][NCYC];

  function automatic logic [31:0] image(input int k);
    case (k)
      'h40:    return 32'h80FF_7F01;   // 0x100
      'h80:    return 32'h1122_3344;   // 0x200
      'hC0:    return 32'h0102_0304;   // 0x300
      default: return 32'h0;
    endcase
  endfunction

  function automatic void chk1(input int g, input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL i%0d %s: got %0b, expected %0b (cycle %0d)", g, name, act, exp, cyc);
    end
  endfunction

  function automatic void chk32(input int g, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL i%0d %s: got 0x%08h, expected 0x%08h (cycle %0d)", g, name, act, exp, cyc);
    end
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int RL = (g == 0) ? 1 : 3;
    load_store_unit #(.READ_LATENCY(RL)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n[g]),
      .reqValid    (req_valid[g]),
      .reqReady    (req_ready[g]),
      .reqWrite    (req_write[g]),
      .reqFunct3   (req_funct3[g]),
      .reqAddress  (req_address[g]),
      .reqWriteData(req_wdata[g]),
      .respValid   (resp_valid[g]),
      .respData    (resp_data[g]),
      .respError   (resp_error[g]),
      .memRead     (mem_read[g]),
      .memWrite    (mem_write[g]),
      .memAddress  (mem_addr[g]),
      .memWriteData(mem_wdata[g]),
      .memReadData (mem_rdata[g])
    );
    // Outside the valid cycle the read bus carries junk so a mistimed capture shows up.
    assign mem_rdata[g] = pipe_v[g][RL-1] ? pipe_d[g][RL-1] : 32'hDEAD_0BAD;
  end

  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (!env_init) begin
        for (int k = 0; k < NW; k++) env_mem[g][k] <= image(k);
        pipe_v[g] <= 3'b000;
        wr_cnt[g] <= 0;
      end else begin
        pipe_v[g]    <= {pipe_v[g][1:0], mem_read[g]};
        pipe_d[g][0] <= env_mem[g][mem_addr[g][9:2]];
        pipe_d[g][1] <= pipe_d[g][0];
        pipe_d[g][2] <= pipe_d[g][1];
        if (mem_write[g]) begin
          env_mem[g][mem_addr[g][9:2]] <= mem_wdata[g];
          wr_cnt[g] <= wr_cnt[g] + 1;
        end
      end
    end
    env_init <= 1'b1;
  end

  // Work out everything an accepted request must produce, from size/offset arithmetic.
  task automatic model_accept(input int g, input int a);
    int rl, sz, sh;
    bit w, bad;
    logic [2:0]  f;
    logic [31:0] wa, word, mask, val;
    rl   = (g == 0) ? 1 : 3;
    f    = req_funct3[g];
    w    = req_write[g];
    wa   = req_address[g] & 32'hFFFF_FFFC;
    sz   = 1 << f[1:0];
    sh   = 8 * int'(req_address[g][1:0]);
    bad  = (f == 3'b011) || (f == 3'b110) || (f == 3'b111) || (w && f[2]) ||
           ((req_address[g] % sz) != 0);
    mask = (sz >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
    word = model_mem[g][wa[9:2]];
    model_acc[g]++;
    if (bad) begin
      exp_rv[g][a+1] = 1'b1; exp_re[g][a+1] = 1'b1; exp_rdat[g][a+1] = 32'h0;
      busy_until[g] = a + 1;
    end else if (!w || sz < 4) begin
      exp_rd[g][a+1] = 1'b1; exp_addr[g][a+1] = wa;
      for (int k = a + 2; k <= a + 1 + rl; k++) begin
        exp_hold[g][k] = 1'b1; exp_addr[g][k] = wa;
      end
      if (!w) begin
        val = (word >> sh) & mask;
        if (!f[2] && sz < 4 && val[8*sz-1]) val = val | ~mask;
        exp_rv[g][a+2+rl] = 1'b1; exp_re[g][a+2+rl] = 1'b0; exp_rdat[g][a+2+rl] = val;
        busy_until[g] = a + 2 + rl;
      end else begin
        exp_wr[g][a+2+rl]   = 1'b1;
        exp_addr[g][a+2+rl] = wa;
        exp_wd[g][a+2+rl]   = (word & ~(mask << sh)) | ((req_wdata[g] & mask) << sh);
        exp_rv[g][a+3+rl] = 1'b1; exp_re[g][a+3+rl] = 1'b0; exp_rdat[g][a+3+rl] = 32'h0;
        busy_until[g] = a + 3 + rl;
      end
    end else begin
      exp_wr[g][a+1] = 1'b1; exp_addr[g][a+1] = wa; exp_wd[g][a+1] = req_wdata[g];
      exp_rv[g][a+2] = 1'b1; exp_re[g][a+2] = 1'b0; exp_rdat[g][a+2] = 32'h0;
      busy_until[g] = a + 2;
    end
  endtask

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin : cmp
    int c;
    bit rdy_exp;
    if (!cmp_init) begin
      for (int g = 0; g < NI; g++) begin
        for (int k = 0; k < NW; k++) model_mem[g][k] = image(k);
        busy_until[g] = 0;
        model_acc[g]  = 0;
      end
      cmp_init = 1'b1;
    end
    c = cyc;
    for (int g = 0; g < NI; g++) begin
      if (c < NCYC - 8) begin
        if (!rst_n[g]) begin
          chk1(g, "rst_resp_valid", resp_valid[g], 1'b0);
          chk1(g, "rst_resp_error", resp_error[g], 1'b0);
          chk1(g, "rst_mem_read", mem_read[g], 1'b0);
          chk1(g, "rst_mem_write", mem_write[g], 1'b0);
          chk32(g, "rst_resp_data", resp_data[g], 32'h0);
          chk32(g, "rst_mem_addr", mem_addr[g], 32'h0);
          chk32(g, "rst_mem_wdata", mem_wdata[g], 32'h0);
          for (int k = c; k < NCYC; k++) begin
            exp_rd[g][k] = 1'b0; exp_wr[g][k] = 1'b0; exp_hold[g][k] = 1'b0; exp_rv[g][k] = 1'b0;
          end
          busy_until[g] = c;
        end else begin
          rdy_exp = (c > busy_until[g]);
          chk1(g, "req_ready", req_ready[g], rdy_exp);
          chk1(g, "mem_read", mem_read[g], exp_rd[g][c]);
          chk1(g, "mem_write", mem_write[g], exp_wr[g][c]);
          chk1(g, "resp_valid", resp_valid[g], exp_rv[g][c]);
          if (exp_rd[g][c] || exp_hold[g][c] || exp_wr[g][c])
            chk32(g, "mem_addr", mem_addr[g], exp_addr[g][c]);
          if (exp_wr[g][c]) begin
            chk32(g, "mem_wdata", mem_wdata[g], exp_wd[g][c]);
            model_mem[g][exp_addr[g][c][9:2]] = exp_wd[g][c];
          end
          if (exp_rv[g][c]) begin
            chk1(g, "resp_error", resp_error[g], exp_re[g][c]);
            chk32(g, "resp_data", resp_data[g], exp_rdat[g][c]);
          end
          if (req_valid[g] && rdy_exp) model_accept(g, c);
        end
      end
    end
  end

  // One request with hand-computed latency/data/error.
  task automatic do_req(input int g, input string name, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input bit hold,
                        input int exp_lat, input logic [31:0] exp_d, input logic exp_e);
    int acc, lat;
    acc = -1;
    lat = -1;
    @(posedge clk); #1;
    req_valid[g] = 1'b1; req_write[g] = w; req_funct3[g] = f3;
    req_address[g] = a;  req_wdata[g] = wd;
    for (int k = 0; k < 8 && acc < 0; k++) begin
      @(negedge clk);
      if (req_ready[g]) acc = cyc;
    end
    if (acc < 0) begin
      chk1(g, {name, "_accept_timeout"}, 1'b0, 1'b1);
      req_valid[g] = 1'b0;
      return;
    end
    if (!hold) begin
      @(posedge clk); #1;
      req_valid[g] = 1'b0;
    end
    for (int k = 0; k < 12 && lat < 0; k++) begin
      @(negedge clk);
      if (resp_valid[g]) begin
        lat = cyc - acc;
        chk1(g, {name, "_error"}, resp_error[g], exp_e);
        chk32(g, {name, "_data"}, resp_data[g], exp_d);
      end
    end
    chk32(g, {name, "_latency"}, lat, exp_lat);
    if (hold) begin
      @(posedge clk); #1;
      req_valid[g] = 1'b0;
    end
  endtask

  task automatic reset_mid_sb();
    int w0;
    @(posedge clk); #1;
    w0 = wr_cnt[0];
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_funct3[0] = 3'b000;
    req_address[0] = 32'h301; req_wdata[0] = 32'h99;
    @(negedge clk);
    chk1(0, "rst_test_accept", req_ready[0], 1'b1);
    @(posedge clk); #1;               // RD_REQ
    req_valid[0] = 1'b0;
    @(posedge clk); #1;               // RD_WAIT, the cycle before WR
    rst_n[0] = 1'b0;
    @(negedge clk);
    chk1(0, "rst_test_mem_write", mem_write[0], 1'b0);
    chk32(0, "rst_test_mem_addr", mem_addr[0], 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n[0] = 1'b1;
    @(negedge clk);
    chk1(0, "rst_test_ready", req_ready[0], 1'b1);
    repeat (4) @(posedge clk);
    chk32(0, "rst_test_wr_cnt", wr_cnt[0], w0);
    chk32(0, "rst_test_word", env_mem[0]['hC0], 32'h0102_0304);
  endtask

  initial begin
    int acc0;
    for (int g = 0; g < NI; g++) begin
      rst_n[g] = 1'b0; req_valid[g] = 1'b0; req_write[g] = 1'b0;
      req_funct3[g] = 3'd0; req_address[g] = 32'h0; req_wdata[g] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) rst_n[g] = 1'b1;

    // Loads from 0x100 = 0x80FF7F01, READ_LATENCY=1.
    do_req(0, "lb_101",  1'b0, 3'b000, 32'h101, 32'h0, 1'b0, 3, 32'h0000_007F, 1'b0);
    do_req(0, "lbu_101", 1'b0, 3'b100, 32'h101, 32'h0, 1'b0, 3, 32'h0000_007F, 1'b0);
    do_req(0, "lh_102",  1'b0, 3'b001, 32'h102, 32'h0, 1'b0, 3, 32'hFFFF_80FF, 1'b0);
    do_req(0, "lhu_102", 1'b0, 3'b101, 32'h102, 32'h0, 1'b0, 3, 32'h0000_80FF, 1'b0);
    do_req(0, "lw_100",  1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 3, 32'h80FF_7F01, 1'b0);
    do_req(0, "lb_103",  1'b0, 3'b000, 32'h103, 32'h0, 1'b0, 3, 32'hFFFF_FF80, 1'b0);

    // Read-modify-write on 0x200 = 0x11223344; upper store-data bits must be ignored.
    do_req(0, "sb_203", 1'b1, 3'b000, 32'h203, 32'h1234_56AA, 1'b0, 4, 32'h0, 1'b0);
    chk32(0, "sb_203_word", env_mem[0]['h80], 32'hAA22_3344);
    do_req(0, "sh_200", 1'b1, 3'b001, 32'h200, 32'hFFFF_5566, 1'b0, 4, 32'h0, 1'b0);
    chk32(0, "sh_200_word", env_mem[0]['h80], 32'hAA22_5566);

    // Full-word store, no read.
    do_req(0, "sw_200", 1'b1, 3'b010, 32'h200, 32'hDEAD_BEEF, 1'b0, 2, 32'h0, 1'b0);
    chk32(0, "sw_200_word", env_mem[0]['h80], 32'hDEAD_BEEF);

    // Rejected requests: response next cycle, no memory traffic.
    do_req(0, "lw_102_mis",  1'b0, 3'b010, 32'h102, 32'h0, 1'b0, 1, 32'h0, 1'b1);
    do_req(0, "sh_001_mis",  1'b1, 3'b001, 32'h001, 32'h0, 1'b0, 1, 32'h0, 1'b1);
    do_req(0, "ld_011_ill",  1'b0, 3'b011, 32'h100, 32'h0, 1'b0, 1, 32'h0, 1'b1);
    do_req(0, "sbu_100_ill", 1'b1, 3'b100, 32'h100, 32'h0, 1'b0, 1, 32'h0, 1'b1);

    reset_mid_sb();

    // READ_LATENCY=3 with reqValid held through the whole operation.
    acc0 = model_acc[1];
    do_req(1, "lw_rl3", 1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 5, 32'h80FF_7F01, 1'b0);
    repeat (3) @(posedge clk);
    chk32(1, "lw_rl3_accepts", model_acc[1] - acc0, 32'd1);
    do_req(1, "sb_rl3", 1'b1, 3'b000, 32'h201, 32'h77, 1'b0, 6, 32'h0, 1'b0);
    chk32(1, "sb_rl3_word", env_mem[1]['h80], 32'h1122_7744);

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
